// File: rtl/servant_acc_pkg.sv
// Shared constants for the servant bus matrix-multiply accelerator.
// Register map word indices, CTRL bit positions and the FSM state type.
// Imported by servant_acc and servant_acc_mac.
package servant_acc_pkg;

    // Word indices on the 13-bit accelerator address bus.
    localparam logic [12:0] REG_CTRL = 13'h000;
    localparam logic [12:0] REG_CYC  = 13'h001;
    localparam logic [12:0] BASE_A   = 13'h100;
    localparam logic [12:0] BASE_B   = 13'h200;
    localparam logic [12:0] BASE_C   = 13'h300;

    // CTRL write bits.
    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;

    // STAT read bits.
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/servant_acc_mac.sv
// Purpose: DW-bit multiply-accumulate, acc_next = (clr ? 0 : acc) + a*b mod 2^DW.
// Latency: purely combinational. Backpressure: none.
// Ports: a_i/b_i operands, acc_i running sum, clr_i drops acc_i, acc_next_o result.
module servant_acc_mac
    import servant_acc_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] acc_i,
    input  logic          clr_i,
    output logic [DW-1:0] acc_next_o
);

    // The low DW bits of a two's-complement product are identical for
    // signed and unsigned operands, so a DW x DW -> DW multiply gives the
    // truncated signed product directly.
    logic [DW-1:0] prod;
    logic [DW-1:0] base;

    assign prod       = a_i * b_i;
    assign base       = clr_i ? '0 : acc_i;
    assign acc_next_o = base + prod;

endmodule

// File: rtl/servant_acc.sv
// Purpose: memory-mapped N x N integer matrix multiply C = A x B, one MAC per cycle.
// Latency: reads return one cycle after the address; a run takes N^3 cycles.
// Backpressure: none; writes to A/B while busy, and all writes to C, are dropped.
// Ports: i_clk, i_rst (sync, active-high), i_wb_adr word address, i_wb_dat write
//        data, i_wb_we qualified write strobe, o_wb_rdt registered read data,
//        o_done DONE flag level.
module servant_acc
    import servant_acc_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [12:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    output logic [31:0] o_wb_rdt,
    output logic        o_done
);

    localparam int NN = N * N;
    localparam int EW = $clog2(NN);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [8:0]    NN9  = 9'(NN);

    // Matrix storage, row-major, deliberately without reset.
    logic [DW-1:0] mem_a [NN];
    logic [DW-1:0] mem_b [NN];
    logic [DW-1:0] mem_c [NN];

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic [31:0]   cyc_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    logic [IW-1:0] k_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic [31:0]   rdt_q;
    logic [31:0]   rdt_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [7:0]    off;
    logic [EW-1:0] eidx;
    logic          in_rng;
    logic          rgn_a;
    logic          rgn_b;
    logic          rgn_c;
    logic          ctrl_wr;
    logic [DW-1:0] wdat;

    assign off     = i_wb_adr[7:0];
    assign eidx    = EW'(off);
    // Offsets beyond N*N inside a matrix window are holes that read 0.
    assign in_rng  = ({1'b0, off} < NN9);
    assign rgn_a   = (i_wb_adr[12:8] == BASE_A[12:8]);
    assign rgn_b   = (i_wb_adr[12:8] == BASE_B[12:8]);
    assign rgn_c   = (i_wb_adr[12:8] == BASE_C[12:8]);
    assign ctrl_wr = i_wb_we && (i_wb_adr == REG_CTRL);
    assign wdat    = DW'(i_wb_dat);

    function automatic logic [31:0] ext(input logic [DW-1:0] v);
        return 32'($signed(v));
    endfunction

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [EW-1:0] a_idx;
    logic [EW-1:0] b_idx;
    logic [EW-1:0] c_idx;
    logic          last_k;

    assign a_idx  = EW'(int'(i_q) * N + int'(k_q));
    assign b_idx  = EW'(int'(k_q) * N + int'(j_q));
    assign c_idx  = EW'(int'(i_q) * N + int'(j_q));
    assign last_k = (k_q == LAST);

    // acc_q is already zero at k==0; clr makes each dot product independent
    // of accumulator history regardless.
    servant_acc_mac #(
        .DW (DW)
    ) u_mac (
        .a_i        (mem_a[a_idx]),
        .b_i        (mem_b[b_idx]),
        .acc_i      (acc_q),
        .clr_i      (k_q == '0),
        .acc_next_o (acc_d)
    );

    // ------------------------------------------------------------------
    // Read mux, registered below; answers every cycle regardless of we.
    // ------------------------------------------------------------------
    always_comb begin
        rdt_d = '0;
        if (i_wb_adr == REG_CTRL) begin
            rdt_d[STAT_BUSY] = busy_q;
            rdt_d[STAT_DONE] = done_q;
        end else if (i_wb_adr == REG_CYC) begin
            rdt_d = cyc_q;
        end else if (in_rng) begin
            if (rgn_a)      rdt_d = ext(mem_a[eidx]);
            else if (rgn_b) rdt_d = ext(mem_b[eidx]);
            else if (rgn_c) rdt_d = ext(mem_c[eidx]);
        end
    end

    // ------------------------------------------------------------------
    // Storage writes
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_wb_we && !busy_q && in_rng) begin
            if (rgn_a) mem_a[eidx] <= wdat;
            if (rgn_b) mem_b[eidx] <= wdat;
        end
        if (!i_rst && state_q == RUN && last_k) begin
            mem_c[c_idx] <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with index counters and status
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            rdt_q   <= '0;
        end else begin
            rdt_q <= rdt_d;
            case (state_q)
                IDLE: begin
                    // Start wins over clear when both bits are set.
                    if (ctrl_wr && i_wb_dat[CTRL_START]) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cyc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
                    end else if (ctrl_wr && i_wb_dat[CTRL_CLR]) begin
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    cyc_q <= cyc_q + 32'd1;
                    if (last_k) begin
                        acc_q <= '0;
                        k_q   <= '0;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            if (i_q == LAST) begin
                                i_q     <= '0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                i_q <= i_q + 1'b1;
                            end
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        acc_q <= acc_d;
                        k_q   <= k_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_servant_acc.sv
// Purpose: self-checking bench for servant_acc (N=4, DW=32) with a read scoreboard.
// Latency: expected read data is queued at address drive, popped one cycle later.
// Backpressure: none.
module tb_servant_acc;

    logic        clk;
    logic        rst;
    logic [12:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [31:0] rdt;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] ma [16];
    logic [31:0] mb [16];
    logic [31:0] exp_q [$];

    servant_acc #(
        .N  (4),
        .DW (32)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wb_adr (adr),
        .i_wb_dat (dat),
        .i_wb_we  (we),
        .o_wb_rdt (rdt),
        .o_done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d);
        adr = a;
        dat = d;
        we  = 1'b1;
        @(posedge clk);
        #1;
        we  = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        adr = a;
        we  = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, rdt, exp_q.pop_front());
    endtask

    function automatic logic [31:0] model_c(input int i, input int j);
        logic [31:0] s = 32'd0;
        for (int k = 0; k < 4; k++) s = s + ma[i*4+k] * mb[k*4+j];
        return s;
    endfunction

    task automatic load();
        for (int e = 0; e < 16; e++) wr(13'h100 + 13'(e), ma[e]);
        for (int e = 0; e < 16; e++) wr(13'h200 + 13'(e), mb[e]);
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                rd(13'h300 + 13'(i*4+j), model_c(i, j), tag);
    endtask

    // mode 0: plain run (start strobe held two cycles)
    // mode 1: A write at cycle 10 and re-start at cycle 11 while busy
    // mode 2: reset asserted on the 20th run edge
    task automatic run(input int mode, input logic [31:0] ctrl, output int n);
        wr(13'h000, ctrl);
        n = 0;
        while (n < 200) begin
            we  = 1'b0;
            adr = 13'h000;
            if (mode == 0 && n == 0) begin dat = 32'd1; we = 1'b1; end
            if (mode == 1 && n == 9) begin adr = 13'h100; dat = 32'd99; we = 1'b1; end
            if (mode == 1 && n == 10) begin dat = 32'd1; we = 1'b1; end
            if (mode == 2 && n == 19) rst = 1'b1;
            @(posedge clk);
            #1;
            n++;
            rst = 1'b0;
            we  = 1'b0;
            if (n == 1) chk("busy_after_start", rdt, 32'h1);
            if (mode == 2 && n == 20) break;
            if (done) break;
        end
        if (mode != 2) begin
            chk("done_latency", 32'(n), 32'd64);
            rd(13'h000, 32'h2, "stat_done");
            rd(13'h001, 32'd64, "cycles");
        end
    endtask

    int n;

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        adr = '0;
        dat = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("reset_done", 32'(done), 32'd0);
        rd(13'h000, 32'd0, "reset_stat");
        rd(13'h001, 32'd0, "reset_cycles");

        // Identity x sequence
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i*4+j] = (i == j) ? 32'd1 : 32'd0;
                mb[i*4+j] = 32'(i*4 + j + 1);
            end
        load();
        run(0, 32'd1, n);
        check_c("c_identity");

        // All 2 x all 3
        for (int e = 0; e < 16; e++) begin ma[e] = 32'd2; mb[e] = 32'd3; end
        load();
        run(0, 32'd1, n);
        check_c("c_const");
        chk("c_const_24", model_c(2, 1), 32'd24);

        // Wrap; start+clear together while DONE is set
        for (int e = 0; e < 16; e++) begin ma[e] = 32'd0; mb[e] = 32'd0; end
        ma[0] = 32'h7FFF_FFFF;
        mb[0] = 32'd2;
        load();
        wr(13'h000, 32'h3);
        chk("startclr_done_low", 32'(done), 32'd0);
        rd(13'h000, 32'h1, "startclr_busy");
        n = 0;
        while (n < 200 && !done) begin @(posedge clk); #1; n++; end
        chk("wrap_done_seen", 32'(done), 32'd1);
        check_c("c_wrap");
        rd(13'h300, 32'hFFFF_FFFE, "c_wrap_00");

        // Disturbed run, signed operands
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i*4+j] = 32'(i + j - 3);
                mb[i*4+j] = 32'(i*4 + j + 1);
            end
        load();
        run(1, 32'd1, n);
        check_c("c_disturbed");
        rd(13'h100, ma[0], "a00_kept");

        // Reset mid-run, then fresh run
        run(2, 32'd1, n);
        chk("rst_mid_done", 32'(done), 32'd0);
        rd(13'h000, 32'd0, "rst_mid_stat");
        run(0, 32'd1, n);
        check_c("c_after_rst");

        // Writes to C and holes are ignored; holes read 0; clear DONE
        wr(13'h300, 32'hDEAD_BEEF);
        wr(13'h3FF, 32'hDEAD_BEEF);
        rd(13'h300, model_c(0, 0), "c00_write_ignored");
        rd(13'h004, 32'd0, "hole_004");
        rd(13'h1FF, 32'd0, "hole_1ff");
        rd(13'h3FF, 32'd0, "hole_3ff");
        wr(13'h000, 32'h2);
        chk("clr_done_level", 32'(done), 32'd0);
        rd(13'h000, 32'd0, "clr_done_stat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
